fir4avg_sum_decoder: RTL and testbench
======================================

// Module: fir4avg_sum_decoder
// PURPOSE
//  Inverse of the 4-tap unsigned averaging FIR. Accepts the filter's (W+2)-bit running
//  4-sample sum stream and recovers the original W-bit sample stream using
//  x[n] = S[n] - S[n-1] + x[n-4].
//  Sits at the receive end of the FIR datapath for bit-exact loopback checking and
//  sample reconstruction.
//  Valid/ready on both sides. One output register stage.
// PARAMETERS
//  W       16  sample width; sum input is W+2 bits
// PORTS
//  clk        in   1    rising-edge clock
//  reset      in   1    asynchronous, active-low reset
//  s_in       in   W+2  4-tap sum sample
//  in_valid   in   1    s_in is valid
//  in_ready   out  1    decoder can accept s_in this cycle
//  x_out      out  W    recovered sample
//  out_valid  out  1    x_out is valid
//  out_ready  in   1    consumer accepts x_out
//  err        out  1    sticky: a recovered value fell outside [0, 2^W-1]
//  err_cnt    out  8    (FIR4DEC_ERR_CNT_EN only) saturating error count
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - s_prev=0, history x1..x4=0, x_out=0, out_valid=0, err=0, err_cnt=0.
//   - This matches the FIR's zeroed delay line, so the first sum decodes with no warm-up.
//  Handshake:
//   - in_ready = !out_valid || out_ready (combinational).
//   - Accept when in_valid && in_ready.
//   - out_valid/x_out hold stable until out_ready is high.
//   - out_valid clears on a consume with no simultaneous accept.
//   - Simultaneous accept and consume: the new result replaces the old one in the same
//     edge; out_valid stays 1.
//  Latency: 1 cycle from accept to out_valid, with zero bubbles at full throughput.
//  On accept:
//   - d = $signed({2'b0,s_in}) - $signed({2'b0,s_prev}) + $signed({3'b0,x4}), computed in
//     W+4 bits signed.
//   - If 0 <= d <= 2^W-1: x_out = d[W-1:0].
//   - Otherwise: x_out saturates (0 if d<0, 2^W-1 if d>2^W-1) and err is set.
//   - s_prev <= s_in. History shifts: x4<=x3, x3<=x2, x2<=x1, x1<=x_out(saturated value).
//  No accept: all state holds.
//  err clears only on reset.
//  Reset asserted mid-stream: all state clears immediately and the output is dropped.
//  Upstream must also reset its FIR so both sides restart from zero.
// CONFIGURATION
//  FIR4DEC_ERR_CNT_EN defined:
//   - err_cnt port exists.
//   - Increments on each out-of-range accept and saturates at 255.
//  FIR4DEC_ERR_CNT_EN undefined:
//   - Port and counter are absent.
//   - Sticky err is always present.
// STRUCTURE
//  Package fir4_pkg:
//   - W_DEF = 16.
//   - typedef sample_t = logic [W_DEF-1:0].
//   - typedef sum_t = logic [W_DEF+1:0].
//   - localparam SUM_W = W_DEF+2.
//  Sub-module fir4dec_hist: 4-deep W-bit shift register.
//   - Inputs: shift enable, d. Output: q4.
//   - Async active-low reset to 0.
//  Top level holds s_prev, the arithmetic/saturation, the output register and the
//  error logic.
// TESTING (bench drives s_in from a golden 4-tap FIR model)
//  1. Ramp, in_valid=1, out_ready=1.
//     a=10,20,30,40,50 gives S=10,30,60,100,140.
//     Expect x_out=10,20,30,40,50 one cycle after each accept; err=0.
//  2. Full-scale input.
//     a=65535 x6 gives S=65535,131070,196605,262140,262140,262140.
//     Expect x_out=65535 x6 with no false err.
//  3. Corrupt stream: S=100, then S=0.
//     Expect x_out=100, then x_out=0 (d=-100), err=1 sticky.
//     With FIR4DEC_ERR_CNT_EN: err_cnt=1.
//  4. Backpressure: out_ready=0 for 3 cycles while in_valid=1.
//     Expect in_ready=0, x_out/out_valid held, no state advance.
//     Release: the stream resumes in order with no loss or duplication.
//  5. Reset mid-stream: assert reset after 3 accepts, release, then feed a fresh
//     FIR stream a=7,7,7,7 (S=7,14,21,28).
//     Expect out_valid=0 during reset, then x_out=7 x4.
//  6. Random a[] of length 1000 with random in_valid/out_ready.
//     Output equals input exactly; err=0; err_cnt stays 0 when compiled in.

Source files
------------

// File: rtl/fir4_pkg.sv
// ---------------------------------------------------------------------------
// fir4_pkg
// Shared widths and types for the 4-tap averaging FIR sum decoder.
//   W_DEF    : default sample width
//   SUM_W    : width of the running 4-sample sum (W_DEF+2)
//   sample_t : one recovered sample
//   sum_t    : one 4-tap sum sample
// ---------------------------------------------------------------------------
package fir4_pkg;

  localparam int W_DEF = 16;
  localparam int SUM_W = W_DEF + 2;

  typedef logic [W_DEF-1:0] sample_t;
  typedef logic [W_DEF+1:0] sum_t;

endpackage

// File: rtl/fir4avg_sum_decoder_if.sv
// ---------------------------------------------------------------------------
// fir4avg_sum_decoder_if
// Valid/ready stream bundle for the FIR sum decoder.
//   s_in / in_valid / in_ready    : sum stream into the decoder
//   x_out / out_valid / out_ready : recovered sample stream out of the decoder
// Modports:
//   slave  : the decoder (consumes sums, produces samples)
//   master : the environment (produces sums, consumes samples)
// ---------------------------------------------------------------------------
interface fir4avg_sum_decoder_if #(
  parameter int W = fir4_pkg::W_DEF
);

  logic [W+1:0] s_in;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x_out;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  s_in,
    input  in_valid,
    output in_ready,
    output x_out,
    output out_valid,
    input  out_ready
  );

  modport master (
    output s_in,
    output in_valid,
    input  in_ready,
    input  x_out,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/fir4dec_hist.sv
// ---------------------------------------------------------------------------
// fir4dec_hist
// Four-deep shift register holding the last four recovered samples.
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset, clears all stages to 0
//   shift_en : advance the history by one sample
//   d        : newest recovered sample
//   q4       : sample recovered four accepts ago (x[n-4])
// ---------------------------------------------------------------------------
module fir4dec_hist #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q4
);

  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [W-1:0] x3;

  // History only moves on an accepted sum so it stays aligned with the
  // upstream FIR delay line; zeros after reset mirror the FIR's initial state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
      q4 <= '0;
    end else if (shift_en) begin
      x1 <= d;
      x2 <= x1;
      x3 <= x2;
      q4 <= x3;
    end
  end

endmodule

// File: rtl/fir4avg_sum_decoder.sv
// ---------------------------------------------------------------------------
// fir4avg_sum_decoder
// Inverse of the 4-tap unsigned averaging FIR: recovers x[n] from the running
// sum stream using x[n] = S[n] - S[n-1] + x[n-4], with one output register.
//   clk     : rising-edge clock
//   reset   : asynchronous active-low reset
//   bus     : valid/ready sum input and sample output (slave modport)
//   err     : sticky flag, a recovered value fell outside [0, 2^W-1]
//   err_cnt : saturating count of out-of-range results (only when the macro
//             FIR4DEC_ERR_CNT_EN is defined)
// ---------------------------------------------------------------------------
module fir4avg_sum_decoder
  import fir4_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  fir4avg_sum_decoder_if.slave    bus,
  output logic                    err
`ifdef FIR4DEC_ERR_CNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  logic [W+1:0]        s_prev;
  logic [W-1:0]        x4;
  logic [W-1:0]        x_sat;
  logic [W-1:0]        x_out_q;
  logic                out_valid_q;
  logic signed [W+3:0] d;
  logic                out_of_range;
  logic                accept;

  // The output register can take a new result when it is empty or is being
  // drained this very cycle, which gives full throughput with no bubbles.
  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign bus.x_out     = x_out_q;
  assign bus.out_valid = out_valid_q;
  assign accept        = bus.in_valid && bus.in_ready;

  // Difference in W+4 signed bits is wide enough for the whole range of
  // S[n] - S[n-1] + x[n-4]; anything negative or above 2^W-1 means the sum
  // stream is corrupt, so clamp and flag it.
  always_comb begin
    d = $signed({2'b00, bus.s_in}) - $signed({2'b00, s_prev})
        + $signed({4'b0000, x4});
    x_sat        = d[W-1:0];
    out_of_range = 1'b0;
    if (d[W+3]) begin
      x_sat        = '0;
      out_of_range = 1'b1;
    end else if (|d[W+2:W]) begin
      x_sat        = '1;
      out_of_range = 1'b1;
    end
  end

  fir4dec_hist #(.W(W)) u_hist (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .d        (x_sat),
    .q4       (x4)
  );

  // Previous sum and output register. A new accept always overwrites the
  // output (covers the simultaneous accept+consume case); a consume alone
  // empties it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_prev      <= '0;
      x_out_q     <= '0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      s_prev      <= bus.s_in;
      x_out_q     <= x_sat;
      out_valid_q <= 1'b1;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Sticky error: once the stream has been seen to be inconsistent it stays
  // flagged until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err <= 1'b0;
    end else if (accept && out_of_range) begin
      err <= 1'b1;
    end
  end

`ifdef FIR4DEC_ERR_CNT_EN
  // Count out-of-range results, holding at 255 rather than wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_cnt <= '0;
    end else if (accept && out_of_range && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fir4avg_sum_decoder.sv
// ---------------------------------------------------------------------------
// tb_fir4avg_sum_decoder
// Self-checking bench for fir4avg_sum_decoder. Sum streams come from fixed
// tables or a golden 4-tap FIR model; expected samples go into a scoreboard
// queue on each accept and are compared when the decoder's output is consumed.
// Honors FIR4DEC_ERR_CNT_EN for the optional err_cnt port.
// ---------------------------------------------------------------------------
module tb_fir4avg_sum_decoder;
  import fir4_pkg::*;

  localparam int W = W_DEF;

  logic clk = 1'b0;
  logic reset;
  logic err;
`ifdef FIR4DEC_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  fir4avg_sum_decoder_if #(.W(W)) bus ();

  fir4avg_sum_decoder #(.W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .err     (err)
`ifdef FIR4DEC_ERR_CNT_EN
    ,
    .err_cnt (err_cnt)
`endif
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  typedef struct {
    sum_t    s;
    sample_t exp_x;
  } vec_t;

  vec_t    ramp_vec[5];
  vec_t    full_vec[6];
  vec_t    corrupt_vec[3];

  int      checks = 0;
  int      errors = 0;
  sample_t sb[$];
  sample_t cur_exp;
  logic    rand_ready = 1'b0;
  sample_t fir_h1, fir_h2, fir_h3;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Golden 4-tap FIR: S[n] = a[n] + a[n-1] + a[n-2] + a[n-3].
  task automatic fir_step(input sample_t a, output sum_t s);
    s = sum_t'(a) + sum_t'(fir_h1) + sum_t'(fir_h2) + sum_t'(fir_h3);
    fir_h3 = fir_h2;
    fir_h2 = fir_h1;
    fir_h1 = a;
  endtask

  task automatic wait_accept();
    bit done = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.in_valid && bus.in_ready) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      errors++;
      $display("[TB] FAIL accept_timeout: got no accept expected accept of %0d", cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input sum_t s, input sample_t exp_x);
    bus.s_in     = s;
    bus.in_valid = 1'b1;
    cur_exp      = exp_x;
    wait_accept();
  endtask

  task automatic send_sample(input sample_t a);
    sum_t s;
    fir_step(a, s);
    apply_stimulus(s, a);
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
      #1;
    end
    check_output("drain_empty", sb.size(), 0);
  endtask

  // Reset the decoder and the golden FIR together, dropping pending output.
  task automatic do_reset();
    bus.in_valid = 1'b0;
    reset        = 1'b0;
    fir_h1 = '0;
    fir_h2 = '0;
    fir_h3 = '0;
    sb.delete();
    #1;
    check_output("rst_out_valid_async", bus.out_valid, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_valid", bus.out_valid, 0);
    check_output("rst_x_out", bus.x_out, 0);
    check_output("rst_err", err, 0);
`ifdef FIR4DEC_ERR_CNT_EN
    check_output("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare on consume, then record on accept.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("[TB] FAIL sb_underflow: got x_out %0d expected nothing", bus.x_out);
          end else begin
            check_output("x_out", bus.x_out, sb.pop_front());
          end
        end
        if (bus.in_valid && bus.in_ready) sb.push_back(cur_exp);
      end
    end
  end

  // Random consumer back-pressure when enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    ramp_vec[0] = '{18'd10,  16'd10};
    ramp_vec[1] = '{18'd30,  16'd20};
    ramp_vec[2] = '{18'd60,  16'd30};
    ramp_vec[3] = '{18'd100, 16'd40};
    ramp_vec[4] = '{18'd140, 16'd50};

    full_vec[0] = '{18'd65535,  16'd65535};
    full_vec[1] = '{18'd131070, 16'd65535};
    full_vec[2] = '{18'd196605, 16'd65535};
    full_vec[3] = '{18'd262140, 16'd65535};
    full_vec[4] = '{18'd262140, 16'd65535};
    full_vec[5] = '{18'd262140, 16'd65535};

    corrupt_vec[0] = '{18'd100, 16'd100};
    corrupt_vec[1] = '{18'd0,   16'd0};
    corrupt_vec[2] = '{18'd0,   16'd0};

    bus.s_in      = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cur_exp       = '0;
    reset         = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] reset state");
    do_reset();
    check_output("idle_in_ready", bus.in_ready, 1);

    $display("[TB] ramp");
    for (int i = 0; i < 5; i++) apply_stimulus(ramp_vec[i].s, ramp_vec[i].exp_x);
    drain();
    check_output("ramp_err", err, 0);

    $display("[TB] full scale");
    do_reset();
    for (int i = 0; i < 6; i++) apply_stimulus(full_vec[i].s, full_vec[i].exp_x);
    drain();
    check_output("full_err", err, 0);

    $display("[TB] corrupt stream");
    do_reset();
    for (int i = 0; i < 3; i++) apply_stimulus(corrupt_vec[i].s, corrupt_vec[i].exp_x);
    drain();
    repeat (3) @(posedge clk);
    #1;
    check_output("corrupt_err_sticky", err, 1);
`ifdef FIR4DEC_ERR_CNT_EN
    check_output("corrupt_err_cnt", err_cnt, 1);
`endif

    $display("[TB] backpressure");
    do_reset();
    bus.out_ready = 1'b0;
    send_sample(16'd1000);
    begin
      sum_t s;
      fir_step(16'd2000, s);
      bus.s_in     = s;
      bus.in_valid = 1'b1;
      cur_exp      = 16'd2000;
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("bp_in_ready", bus.in_ready, 0);
      check_output("bp_out_valid", bus.out_valid, 1);
      check_output("bp_x_out_hold", bus.x_out, 1000);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    wait_accept();
    send_sample(16'd3000);
    send_sample(16'd4000);
    drain();

    $display("[TB] reset mid-stream");
    send_sample(16'd100);
    send_sample(16'd200);
    send_sample(16'd300);
    do_reset();
    for (int i = 0; i < 4; i++) send_sample(16'd7);
    drain();

    $display("[TB] random stream");
    rand_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_sample(16'($urandom_range(0, 65535)));
    end
    bus.in_valid = 1'b0;
    rand_ready   = 1'b0;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();
    check_output("rand_err", err, 0);
`ifdef FIR4DEC_ERR_CNT_EN
    check_output("rand_err_cnt", err_cnt, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
